tetris_seq_ctrl: RTL and testbench
==================================

Name: tetris_seq_ctrl

Overview:
Game sequencer for the Tetris datapath. It owns the state code (GEN/MOVE/LAND/CLEAR/NEWBOARD) that the datapath decodes, and issues one-cycle operation strobes and board-commit strobes. It generates the gravity tick, accepts player moves through a valid/ready handshake, loops on line clears and detects game over. It sits between the input/pad logic and dp, replacing dp's free-running internal state.

Parameters:
GRAVITY_DIV, 16, clka cycles between gravity (fall) steps; must be >= 4
CNT_W, 8, width of cleared-line counter
MAX_CLEAR, 8, max consecutive CLEAR passes per landing (board has 8 rows of 4)

Ports:
clka  in  1  system clock, all logic on posedge
restart  in  1  asynchronous active-high reset
start  in  1  begin/restart game; sampled only in IDLE or OVER
move  in  2  player request: 00 none, 01 left, 10 right, 11 rotate
move_valid  in  1  move holds a request
move_ready  out  1  controller accepts move this cycle
fall_blocked  in  1  dp: last fall could not descend (valid in EVAL phase)
spawn_blocked  in  1  dp: new piece overlaps stack (valid in EVAL phase)
line_full  in  1  dp: line detector found a full row (valid in EVAL phase)
state  out  3  GEN=000 MOVE=001 LAND=010 CLEAR=011 NEWBOARD=100 IDLE=101 OVER=110
move_cmd  out  2  operation for dp in MOVE: 00 fall, else latched player move
dp_en  out  1  one-cycle strobe: dp performs op for current state
board_we  out  1  one-cycle strobe: dp commits temp_board to board_out
board_clr  out  1  one-cycle strobe: dp zeroes board
lines  out  CNT_W  rows cleared this game, saturating
game_over  out  1  high while in OVER

Behaviour:
- Reset (async): state=IDLE, phase=ISSUE, all strobes 0, move_cmd=00, lines=0, game_over=0, gravity counter=0, clear counter=0, move_ready=0.
- GEN/MOVE/LAND/CLEAR each run two phases: ISSUE (dp_en=1, exactly one cycle), then EVAL (next cycle; dp flags sampled, transition decided). Flags are ignored outside EVAL.
- IDLE: start=1 -> board_clr pulse, lines<=0, -> GEN next cycle.
- GEN: EVAL: spawn_blocked=1 -> OVER with no board_we. Otherwise board_we=1, gravity counter<=0, -> MOVE.
- MOVE, gravity: counter increments each cycle in MOVE/ISSUE-wait. At GRAVITY_DIV-1: ISSUE with move_cmd=00, counter<=0.
  - EVAL: fall_blocked=1 -> LAND, no commit.
  - Otherwise board_we=1 and stay in MOVE.
- MOVE, player: move_ready=1 only in MOVE, phase idle, gravity not terminal this cycle, and move!=00.
  - Handshake move_valid&move_ready latches move into move_cmd; ISSUE next cycle; EVAL commits with board_we=1. fall_blocked is ignored for player moves.
  - Gravity terminal and move_valid in the same cycle: gravity wins, move_ready=0, request stays pending.
  - move=00 with valid is never accepted.
- LAND: clear counter<=0 on entry. EVAL: line_full=1 -> CLEAR, else -> NEWBOARD.
- CLEAR: EVAL: board_we=1, lines<=lines+1 saturating at 2^CNT_W-1, clear counter+1. Then -> LAND to re-detect. If clear counter reaches MAX_CLEAR -> NEWBOARD regardless.
- NEWBOARD: board_we=1 for one cycle, -> GEN.
- OVER: game_over=1, lines frozen, all strobes 0. start=1 -> board_clr, lines<=0, game_over<=0, -> GEN.
- start outside IDLE/OVER is ignored.
- restart mid-operation returns everything to reset values immediately. No strobe may be truncated into a glitch, because strobes are registered outputs.
- At most one of dp_en/board_we/board_clr is high in any cycle.

Optional Feature:
PAUSE_EN:
- When defined: adds input pause (1 bit).
- While pause=1 in MOVE with phase idle: gravity counter frozen, move_ready=0. A pause asserted during ISSUE/EVAL takes effect after EVAL.
- pause has no effect in other states.
- When undefined: no pause port; gravity always runs.

Test Plan:
- restart pulse mid-MOVE -> same cycle state=101, lines=0, dp_en=board_we=0; start -> board_clr 1 cycle, then state=000 with dp_en 1 cycle.
- GEN with spawn_blocked=0, hold no moves, GRAVITY_DIV=16 -> fall ISSUE (move_cmd=00, dp_en) every 16 cycles, board_we the cycle after each.
- MOVE, move=01 valid at gravity count 5 -> move_ready=1, move_cmd=01, dp_en next cycle, board_we following; same request at gravity terminal -> move_ready=0, accepted after the fall EVAL.
- fall_blocked=1 in EVAL, line_full=1 on two LAND EVALs then 0 -> sequence LAND,CLEAR,LAND,CLEAR,LAND,NEWBOARD,GEN; lines=2.
- line_full stuck 1 -> exactly 8 CLEAR passes, then NEWBOARD; lines at 254 then further clears -> lines holds 255.
- spawn_blocked=1 in GEN EVAL -> state=110, game_over=1, no board_we; start -> board_clr, lines=0, state=000.

Source files
------------

// File: rtl/tetris_seq_ctrl.sv
// ============================================================================
// Module      : tetris_seq_ctrl
// Description : Game sequencer for the Tetris datapath. Owns the state code
//               decoded by dp, issues registered one-cycle operation and
//               board-commit strobes, generates the gravity tick, accepts
//               player moves over a valid/ready handshake, loops on line
//               clears and detects game over.
//               Optional build macro: PAUSE_EN (adds i_pause input that
//               freezes gravity and move acceptance while idle in MOVE).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_seq_ctrl #(
    parameter int GRAVITY_DIV = 16,
    parameter int CNT_W       = 8,
    parameter int MAX_CLEAR   = 8
) (
    input  logic             i_clka,
    input  logic             i_restart,
    input  logic             i_start,
    input  logic [1:0]       i_move,
    input  logic             i_move_valid,
    output logic             o_move_ready,
    input  logic             i_fall_blocked,
    input  logic             i_spawn_blocked,
    input  logic             i_line_full,
`ifdef PAUSE_EN
    input  logic             i_pause,
`endif
    output logic [2:0]       o_state,
    output logic [1:0]       o_move_cmd,
    output logic             o_dp_en,
    output logic             o_board_we,
    output logic             o_board_clr,
    output logic [CNT_W-1:0] o_lines,
    output logic             o_game_over
);

    localparam int c_GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam int c_CW = $clog2(MAX_CLEAR + 1);
    localparam logic [c_GW-1:0] c_GRAV_TERM = c_GW'(GRAVITY_DIV - 1);
    localparam logic [c_CW-1:0] c_CLR_MAX   = c_CW'(MAX_CLEAR);

    typedef enum logic [2:0] {
        ST_GEN      = 3'b000,
        ST_MOVE     = 3'b001,
        ST_LAND     = 3'b010,
        ST_CLEAR    = 3'b011,
        ST_NEWBOARD = 3'b100,
        ST_IDLE     = 3'b101,
        ST_OVER     = 3'b110
    } state_t;

    // PH_WAIT: MOVE is idle awaiting gravity or a player move.
    // PH_COMMIT: the cycle carrying a registered commit/clear strobe when the
    // following operation must not overlap it (CLEAR, and the IDLE board wipe).
    typedef enum logic [1:0] {
        PH_WAIT   = 2'b00,
        PH_ISSUE  = 2'b01,
        PH_EVAL   = 2'b10,
        PH_COMMIT = 2'b11
    } phase_t;

    state_t            r_state, w_state_nxt;
    phase_t            r_phase, w_phase_nxt;
    logic              r_dp_en, w_dp_en_nxt;
    logic              r_board_we, w_board_we_nxt;
    logic              r_board_clr, w_board_clr_nxt;
    logic [1:0]        r_move_cmd, w_move_cmd_nxt;
    logic [CNT_W-1:0]  r_lines, w_lines_nxt;
    logic              r_game_over, w_game_over_nxt;
    logic [c_GW-1:0]   r_grav, w_grav_nxt;
    logic [c_CW-1:0]   r_clr_cnt, w_clr_cnt_nxt;

    logic              w_pause;
    logic              w_grav_term;
    logic              w_move_ready;
    logic [CNT_W-1:0]  w_lines_inc;

`ifdef PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_grav_term = (r_grav == c_GRAV_TERM);
    // Gravity takes priority: a pending request waits out a terminal cycle.
    assign w_move_ready = (r_state == ST_MOVE) && (r_phase == PH_WAIT) &&
                          !w_grav_term && !w_pause && (i_move != 2'b00);
    assign w_lines_inc  = (&r_lines) ? r_lines : r_lines + CNT_W'(1);

    // State register and registered strobes
    always_ff @(posedge i_clka or posedge i_restart) begin
        if (i_restart) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_ISSUE;
            r_dp_en     <= 1'b0;
            r_board_we  <= 1'b0;
            r_board_clr <= 1'b0;
            r_move_cmd  <= 2'b00;
            r_lines     <= '0;
            r_game_over <= 1'b0;
            r_grav      <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_dp_en     <= w_dp_en_nxt;
            r_board_we  <= w_board_we_nxt;
            r_board_clr <= w_board_clr_nxt;
            r_move_cmd  <= w_move_cmd_nxt;
            r_lines     <= w_lines_nxt;
            r_game_over <= w_game_over_nxt;
            r_grav      <= w_grav_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
        end
    end

    // Next-state, next-strobe and counter logic
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_dp_en_nxt     = 1'b0;
        w_board_we_nxt  = 1'b0;
        w_board_clr_nxt = 1'b0;
        w_move_cmd_nxt  = r_move_cmd;
        w_lines_nxt     = r_lines;
        w_game_over_nxt = r_game_over;
        w_grav_nxt      = r_grav;
        w_clr_cnt_nxt   = r_clr_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (r_phase == PH_COMMIT) begin
                    // Board wipe done; spawn the first piece.
                    w_state_nxt = ST_GEN;
                    w_phase_nxt = PH_ISSUE;
                    w_dp_en_nxt = 1'b1;
                end else if (i_start) begin
                    w_phase_nxt     = PH_COMMIT;
                    w_board_clr_nxt = 1'b1;
                    w_lines_nxt     = '0;
                end
            end

            ST_OVER: begin
                if (i_start) begin
                    w_state_nxt     = ST_IDLE;
                    w_phase_nxt     = PH_COMMIT;
                    w_board_clr_nxt = 1'b1;
                    w_lines_nxt     = '0;
                    w_game_over_nxt = 1'b0;
                end
            end

            ST_GEN: begin
                if (r_phase == PH_ISSUE) begin
                    w_phase_nxt = PH_EVAL;
                end else if (i_spawn_blocked) begin
                    w_state_nxt     = ST_OVER;
                    w_phase_nxt     = PH_WAIT;
                    w_game_over_nxt = 1'b1;
                end else begin
                    w_state_nxt    = ST_MOVE;
                    w_phase_nxt    = PH_WAIT;
                    w_board_we_nxt = 1'b1;
                    w_grav_nxt     = '0;
                end
            end

            ST_MOVE: begin
                if (r_phase == PH_WAIT) begin
                    if (w_pause) begin
                        w_grav_nxt = r_grav;
                    end else if (w_grav_term) begin
                        w_phase_nxt    = PH_ISSUE;
                        w_dp_en_nxt    = 1'b1;
                        w_move_cmd_nxt = 2'b00;
                        w_grav_nxt     = '0;
                    end else begin
                        w_grav_nxt = r_grav + c_GW'(1);
                        if (i_move_valid && w_move_ready) begin
                            w_phase_nxt    = PH_ISSUE;
                            w_dp_en_nxt    = 1'b1;
                            w_move_cmd_nxt = i_move;
                        end
                    end
                end else begin
                    // Gravity keeps time during a player op but holds at
                    // terminal so the fall is issued once the op completes.
                    if (!w_grav_term) begin
                        w_grav_nxt = r_grav + c_GW'(1);
                    end
                    if (r_phase == PH_ISSUE) begin
                        w_phase_nxt = PH_EVAL;
                    end else if ((r_move_cmd == 2'b00) && i_fall_blocked) begin
                        // A fall is the only op that can land the piece.
                        w_state_nxt   = ST_LAND;
                        w_phase_nxt   = PH_ISSUE;
                        w_dp_en_nxt   = 1'b1;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_phase_nxt    = PH_WAIT;
                        w_board_we_nxt = 1'b1;
                    end
                end
            end

            ST_LAND: begin
                if (r_phase == PH_ISSUE) begin
                    w_phase_nxt = PH_EVAL;
                end else if (i_line_full) begin
                    w_state_nxt = ST_CLEAR;
                    w_phase_nxt = PH_ISSUE;
                    w_dp_en_nxt = 1'b1;
                end else begin
                    w_state_nxt    = ST_NEWBOARD;
                    w_phase_nxt    = PH_WAIT;
                    w_board_we_nxt = 1'b1;
                end
            end

            ST_CLEAR: begin
                if (r_phase == PH_ISSUE) begin
                    w_phase_nxt = PH_EVAL;
                end else if (r_phase == PH_EVAL) begin
                    w_phase_nxt    = PH_COMMIT;
                    w_board_we_nxt = 1'b1;
                    w_lines_nxt    = w_lines_inc;
                    w_clr_cnt_nxt  = r_clr_cnt + c_CW'(1);
                end else if (r_clr_cnt >= c_CLR_MAX) begin
                    // Bound the clear loop against a stuck line detector.
                    w_state_nxt    = ST_NEWBOARD;
                    w_phase_nxt    = PH_WAIT;
                    w_board_we_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_LAND;
                    w_phase_nxt = PH_ISSUE;
                    w_dp_en_nxt = 1'b1;
                end
            end

            ST_NEWBOARD: begin
                w_state_nxt = ST_GEN;
                w_phase_nxt = PH_ISSUE;
                w_dp_en_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = PH_ISSUE;
            end
        endcase
    end

    assign o_state      = r_state;
    assign o_move_cmd   = r_move_cmd;
    assign o_dp_en      = r_dp_en;
    assign o_board_we   = r_board_we;
    assign o_board_clr  = r_board_clr;
    assign o_lines      = r_lines;
    assign o_game_over  = r_game_over;
    assign o_move_ready = w_move_ready;

endmodule

`default_nettype wire

// File: tb/tb_tetris_seq_ctrl.sv
// ============================================================================
// Module      : tb_tetris_seq_ctrl
// Description : Self-checking bench for tetris_seq_ctrl (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tetris_seq_ctrl;

    logic       clk = 1'b0;
    logic       i_restart = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_move = 2'b00;
    logic       i_move_valid = 1'b0;
    logic       i_fall_blocked = 1'b0;
    logic       i_spawn_blocked = 1'b0;
    logic       i_line_full = 1'b0;
    logic       o_move_ready;
    logic [2:0] o_state;
    logic [1:0] o_move_cmd;
    logic       o_dp_en;
    logic       o_board_we;
    logic       o_board_clr;
    logic [7:0] o_lines;
    logic       o_game_over;

    always #5 clk = ~clk;

    tetris_seq_ctrl #(.GRAVITY_DIV(16), .CNT_W(8), .MAX_CLEAR(8)) dut (
        .i_clka         (clk),
        .i_restart      (i_restart),
        .i_start        (i_start),
        .i_move         (i_move),
        .i_move_valid   (i_move_valid),
        .o_move_ready   (o_move_ready),
        .i_fall_blocked (i_fall_blocked),
        .i_spawn_blocked(i_spawn_blocked),
        .i_line_full    (i_line_full),
        .o_state        (o_state),
        .o_move_cmd     (o_move_cmd),
        .o_dp_en        (o_dp_en),
        .o_board_we     (o_board_we),
        .o_board_clr    (o_board_clr),
        .o_lines        (o_lines),
        .o_game_over    (o_game_over)
    );

    localparam int S_GEN = 0, S_MOVE = 1, S_LAND = 2, S_CLEAR = 3,
                   S_NB = 4, S_IDLE = 5, S_OVER = 6;

    typedef struct {
        logic       start;
        logic [1:0] mv;
        logic       val, fb, sb, lf;
        logic [2:0] st;
        logic       dp, we, clr;
        logic [1:0] cmd;
        logic       rdy;
        logic [7:0] lines;
        logic       go;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   vec_idx = 0;

    function automatic vec_t v(input int start, input int mv, input int val,
                               input int fb, input int sb, input int lf,
                               input int st, input int dp, input int we,
                               input int clr, input int cmd, input int rdy,
                               input int lines, input int go);
        vec_t r;
        r.start = start[0]; r.mv = mv[1:0]; r.val = val[0];
        r.fb = fb[0]; r.sb = sb[0]; r.lf = lf[0];
        r.st = st[2:0]; r.dp = dp[0]; r.we = we[0]; r.clr = clr[0];
        r.cmd = cmd[1:0]; r.rdy = rdy[0]; r.lines = lines[7:0]; r.go = go[0];
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive each table row just after a clock edge and queue its expectation.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            i_start         = tbl[i].start;
            i_move          = tbl[i].mv;
            i_move_valid    = tbl[i].val;
            i_fall_blocked  = tbl[i].fb;
            i_spawn_blocked = tbl[i].sb;
            i_line_full     = tbl[i].lf;
            sbq.push_back(tbl[i]);
        end
        @(negedge clk);
        #1;
        tbl.delete();
    endtask

    // Scoreboard: compare the DUT mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            vec_t e;
            e = sbq.pop_front();
            n_total++;
            if (o_state == e.st && o_dp_en == e.dp && o_board_we == e.we &&
                o_board_clr == e.clr && o_move_cmd == e.cmd &&
                o_move_ready == e.rdy && o_lines == e.lines &&
                o_game_over == e.go) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got st=%0d dp=%b we=%b clr=%b cmd=%0d rdy=%b lines=%0d go=%b, expected st=%0d dp=%b we=%b clr=%b cmd=%0d rdy=%b lines=%0d go=%b",
                         vec_idx, o_state, o_dp_en, o_board_we, o_board_clr,
                         o_move_cmd, o_move_ready, o_lines, o_game_over,
                         e.st, e.dp, e.we, e.clr, e.cmd, e.rdy, e.lines, e.go);
            end
            vec_idx++;
        end
    end

    initial begin
        int found, n, nclr, started, prev, to, passes, exp_lines, sat, done;
        int seq[$];
        int exp_seq[7];

        // ---------------- reset values ----------------
        #2 i_restart = 1'b1;
        #5;
        chk("rst_state", o_state, S_IDLE);
        chk("rst_strobes", {o_dp_en, o_board_we, o_board_clr}, 0);
        chk("rst_cmd_lines_go", {o_move_cmd, o_lines, o_game_over}, 0);
        chk("rst_ready", o_move_ready, 0);
        @(negedge clk);
        i_restart = 1'b0;

        // ---------------- start, spawn, player moves vs gravity ----------------
        tbl.push_back(v(1,0,0,0,0,0, S_IDLE,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_IDLE,0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_GEN, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_GEN, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,1,0,0,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,0,0,0, S_MOVE,0,0,0,0,1,0,0));   // count 5: accepted
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,1,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, S_MOVE,0,0,0,1,0,0,0));   // fall_blocked ignored
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,1,0,1,0,0,0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,0,0,1,0,0,0));
        tbl.push_back(v(0,2,1,0,0,0, S_MOVE,0,0,0,1,0,0,0));   // terminal: gravity wins
        tbl.push_back(v(0,2,1,0,0,0, S_MOVE,1,0,0,0,0,0,0));
        tbl.push_back(v(0,2,1,0,0,0, S_MOVE,0,0,0,0,0,0,0));
        tbl.push_back(v(0,2,1,0,0,0, S_MOVE,0,1,0,0,1,0,0));   // pending move accepted
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,1,0,0,2,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,0,0,2,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,1,0,2,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S_MOVE,0,0,0,2,0,0,0));   // move=00 never ready
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,0,0,2,0,0,0));
        run_table();

        // ---------------- gravity period ----------------
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_state == 3'(S_MOVE) && o_dp_en && o_move_cmd == 2'b00) begin
                found = 1;
                break;
            end
        end
        chk("grav_first_fall", found, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("grav_eval_no_we", o_board_we, 0);
            @(negedge clk);
            chk("grav_commit_we", o_board_we, 1);
            n = 2;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                n++;
                if (o_dp_en) break;
            end
            chk("grav_period", n, 16);
            chk("grav_cmd_fall", o_move_cmd, 0);
        end

        // ---------------- landing with two line clears ----------------
        i_fall_blocked = 1'b1;
        i_line_full    = 1'b1;
        nclr = 0; started = 0; prev = -1; to = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (o_state == 3'(S_CLEAR) && o_dp_en) begin
                nclr++;
                if (nclr == 2) i_line_full = 1'b0;
            end
            if (o_state == 3'(S_LAND)) started = 1;
            if (started != 0 && int'(o_state) != prev) begin
                seq.push_back(int'(o_state));
                prev = int'(o_state);
            end
            if (started != 0 && o_state == 3'(S_GEN)) begin
                to = 0;
                break;
            end
        end
        chk("clear2_timeout", to, 0);
        exp_seq = '{S_LAND, S_CLEAR, S_LAND, S_CLEAR, S_LAND, S_NB, S_GEN};
        chk("clear2_seq_len", seq.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("clear2_seq[%0d]", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
        end
        chk("clear2_lines", o_lines, 2);

        // ---------------- restart mid-MOVE ----------------
        i_fall_blocked = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_restart_move", o_state, S_MOVE);
        @(posedge clk);
        #2 i_restart = 1'b1;
        #1;
        chk("restart_state", o_state, S_IDLE);
        chk("restart_lines", o_lines, 0);
        chk("restart_dp_we", {o_dp_en, o_board_we}, 0);
        @(negedge clk);
        i_restart = 1'b0;

        tbl.push_back(v(1,0,0,0,0,0, S_IDLE,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_IDLE,0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_GEN, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_GEN, 0,0,0,0,0,0,0));
        run_table();

        // ---------------- stuck line_full: clear bound and saturation ----------------
        i_fall_blocked = 1'b1;
        i_line_full    = 1'b1;
        passes = 0; exp_lines = 0; sat = 0; done = 0; prev = -1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (o_state == 3'(S_CLEAR) && o_dp_en) passes++;
            if (o_state == 3'(S_NB) && prev != S_NB) begin
                chk("clear_passes", passes, 8);
                passes = 0;
            end
            if (o_state == 3'(S_CLEAR) && o_board_we) begin
                exp_lines = (exp_lines < 255) ? exp_lines + 1 : 255;
                chk("lines_sat", o_lines, exp_lines);
                if (exp_lines == 255) sat++;
            end
            prev = int'(o_state);
            if (sat >= 3) begin
                done = 1;
                break;
            end
        end
        chk("sat_reached", done, 1);

        // ---------------- spawn blocked -> game over -> restart game ----------------
        i_fall_blocked  = 1'b0;
        i_line_full     = 1'b0;
        i_spawn_blocked = 1'b1;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (o_state == 3'(S_GEN) && o_dp_en) begin
                found = 1;
                break;
            end
        end
        chk("gen_reached", found, 1);
        tbl.push_back(v(0,0,0,0,1,0, S_GEN, 0,0,0,0,0,255,0));
        tbl.push_back(v(0,0,0,0,1,0, S_OVER,0,0,0,0,0,255,1));
        tbl.push_back(v(1,0,0,0,1,0, S_OVER,0,0,0,0,0,255,1));
        tbl.push_back(v(0,0,0,0,1,0, S_IDLE,0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0, S_GEN, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0, S_GEN, 0,0,0,0,0,0,0));   // start ignored in GEN
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, S_MOVE,0,0,0,0,0,0,0));
        run_table();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
